// File: rtl/golden_sb_pkg.sv
// rtl/golden_sb_pkg.sv - retire record, scoreboard states and field-compare helper
package golden_sb_pkg;

    localparam int PC_W   = 32;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam int MF_PC   = 0;
    localparam int MF_RD   = 1;
    localparam int MF_DATA = 2;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [REG_W-1:0]  rd;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } retire_rec_t;

    typedef enum logic [1:0] {EMPTY, TRACKING, STALLED, HALTED} sb_state_e;

    // A write to x0 is architecturally no write, so it never contributes to rd/data differences.
    function automatic logic [2:0] rec_diff(input retire_rec_t g, input retire_rec_t d);
        logic       eff_g;
        logic       eff_d;
        logic [2:0] f;
        eff_g      = g.we && (g.rd != '0);
        eff_d      = d.we && (d.rd != '0);
        f          = '0;
        f[MF_PC]   = (g.pc != d.pc);
        f[MF_RD]   = (eff_g != eff_d) || (eff_g && eff_d && (g.rd != d.rd));
        f[MF_DATA] = eff_g && eff_d && (g.wdata != d.wdata);
        return f;
    endfunction

endpackage

// File: rtl/golden_sb_fifo.sv
// rtl/golden_sb_fifo.sv - synchronous FIFO of golden retire records
module golden_sb_fifo
    import golden_sb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  retire_rec_t              push_data,
    input  logic                     pop,
    output retire_rec_t              head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    retire_rec_t      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occupancy <= occupancy + OCC_W'(push) - OCC_W'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (occupancy == OCC_W'(DEPTH));
    assign empty = (occupancy == '0);

endmodule

// File: rtl/golden_retire_scoreboard.sv
// rtl/golden_retire_scoreboard.sv - in-order golden vs DUT retire scoreboard; optional GOLDEN_SB_STOP_ON_ERROR_EN
module golden_retire_scoreboard
    import golden_sb_pkg::*;
#(
    parameter int DATA_BITS      = 32,
    parameter int PC_BITS        = 32,
    parameter int REG_ADDR_BITS  = 5,
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       gold_valid,
    input  logic [PC_BITS-1:0]         gold_pc,
    input  logic [REG_ADDR_BITS-1:0]   gold_rd,
    input  logic                       gold_we,
    input  logic [DATA_BITS-1:0]       gold_wdata,
    output logic                       gold_ready,
    input  logic                       dut_valid,
    input  logic [PC_BITS-1:0]         dut_pc,
    input  logic [REG_ADDR_BITS-1:0]   dut_rd,
    input  logic                       dut_we,
    input  logic [DATA_BITS-1:0]       dut_wdata,
    output logic                       match,
    output logic                       mismatch,
    output logic [2:0]                 mismatch_field,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       timeout,
    output logic                       halted,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [31:0]                retired_count,
    output logic [15:0]                error_count
);

    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    sb_state_e         state;
    sb_state_e         state_nxt;
    logic [TMR_W-1:0]  timer;
    logic [TMR_W-1:0]  timer_nxt;
    logic              timeout_evt;

    retire_rec_t       gold_rec;
    retire_rec_t       dut_rec;
    retire_rec_t       head_rec;
    retire_rec_t       ref_rec;
    logic              full;
    logic              empty;
    logic              halt;
    logic              push_en;
    logic              pop_en;
    logic              bypass;
    logic              cmp_en;
    logic              underflow_evt;
    logic              overflow_evt;
    logic [2:0]        diff;
    logic [OCC_W-1:0]  occ_nxt;

`ifdef GOLDEN_SB_STOP_ON_ERROR_EN
    assign halt = (state == HALTED);
`else
    assign halt = 1'b0;
`endif
    assign halted = halt;

    assign gold_rec = '{pc: gold_pc, rd: gold_rd, we: gold_we, wdata: gold_wdata};
    assign dut_rec  = '{pc: dut_pc, rd: dut_rd, we: dut_we, wdata: dut_wdata};

    // An empty FIFO with both strobes compares straight against the incoming record.
    assign pop_en        = dut_valid && !empty && !halt;
    assign bypass        = dut_valid && empty && gold_valid && !halt;
    assign underflow_evt = dut_valid && empty && !gold_valid && !halt;
    assign gold_ready    = !reset && !halt && (!full || pop_en);
    assign push_en       = gold_valid && gold_ready && !bypass;
    assign overflow_evt  = gold_valid && !gold_ready && !halt && !reset;
    assign cmp_en        = pop_en || bypass;
    assign ref_rec       = empty ? gold_rec : head_rec;
    assign diff          = rec_diff(ref_rec, dut_rec);
    assign occ_nxt       = occupancy + OCC_W'(push_en) - OCC_W'(pop_en);

    golden_sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_en),
        .push_data (gold_rec),
        .pop       (pop_en),
        .head      (head_rec),
        .full      (full),
        .empty     (empty),
        .occupancy (occupancy)
    );

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        timeout_evt = 1'b0;
        case (state)
            EMPTY: begin
                if (push_en) begin
                    state_nxt = TRACKING;
                    timer_nxt = '0;
                end
            end
            TRACKING, STALLED: begin
                if (occ_nxt == '0) begin
                    state_nxt = EMPTY;
                    timer_nxt = '0;
                end else if (pop_en) begin
                    state_nxt = TRACKING;
                    timer_nxt = '0;
                end else if (state == TRACKING) begin
                    if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_evt = 1'b1;
                        state_nxt   = STALLED;
                    end else begin
                        timer_nxt = timer + TMR_W'(1);
                    end
                end
            end
            default: begin
            end
        endcase
`ifdef GOLDEN_SB_STOP_ON_ERROR_EN
        if (!halt && ((cmp_en && (diff != 3'b000)) || underflow_evt || timeout_evt)) begin
            state_nxt = HALTED;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            match          <= 1'b0;
            mismatch       <= 1'b0;
            mismatch_field <= 3'b000;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
            timeout        <= 1'b0;
            retired_count  <= '0;
            error_count    <= '0;
        end else begin
            match          <= cmp_en && (diff == 3'b000);
            mismatch       <= cmp_en && (diff != 3'b000);
            mismatch_field <= cmp_en ? diff : 3'b000;
            if (overflow_evt) begin
                overflow <= 1'b1;
            end
            if (underflow_evt) begin
                underflow <= 1'b1;
            end
            if (timeout_evt) begin
                timeout <= 1'b1;
            end
            if (cmp_en && (diff == 3'b000) && (retired_count != '1)) begin
                retired_count <= retired_count + 32'd1;
            end
            if (((cmp_en && (diff != 3'b000)) || underflow_evt) && (error_count != '1)) begin
                error_count <= error_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_golden_retire_scoreboard.sv
// tb/tb_golden_retire_scoreboard.sv - vector table, directed sequences and queue-model random checks
module tb_golden_retire_scoreboard;
    import golden_sb_pkg::*;

    localparam int DEPTH = 8;
    localparam int TMO   = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        gold_valid, gold_we, gold_ready, dut_valid, dut_we;
    logic [31:0] gold_pc, gold_wdata, dut_pc, dut_wdata;
    logic [4:0]  gold_rd, dut_rd;
    logic        match, mismatch, overflow, underflow, timeout, halted;
    logic [2:0]  mismatch_field;
    logic [3:0]  occupancy;
    logic [31:0] retired_count;
    logic [15:0] error_count;

    always #5 clk = ~clk;

    golden_retire_scoreboard #(
        .DATA_BITS(32), .PC_BITS(32), .REG_ADDR_BITS(5), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .gold_valid(gold_valid), .gold_pc(gold_pc), .gold_rd(gold_rd), .gold_we(gold_we),
        .gold_wdata(gold_wdata), .gold_ready(gold_ready),
        .dut_valid(dut_valid), .dut_pc(dut_pc), .dut_rd(dut_rd), .dut_we(dut_we), .dut_wdata(dut_wdata),
        .match(match), .mismatch(mismatch), .mismatch_field(mismatch_field),
        .overflow(overflow), .underflow(underflow), .timeout(timeout), .halted(halted),
        .occupancy(occupancy), .retired_count(retired_count), .error_count(error_count)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: queue of outstanding golden records plus flags and counters.
    retire_rec_t q[$];
    int          m_age;
    bit          m_over, m_under, m_tout, m_halt, m_match, m_mm;
    logic [2:0]  m_mf;
    logic [31:0] m_ret;
    logic [15:0] m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic retire_rec_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                       input logic we, input logic [31:0] wd);
        retire_rec_t r;
        r.pc = pc; r.rd = rd; r.we = we; r.wdata = wd;
        return r;
    endfunction

    function automatic logic [2:0] exp_fields(input retire_rec_t g, input retire_rec_t d);
        bit gw, dw;
        logic [2:0] f;
        gw = (g.we == 1'b1) && (g.rd != 5'd0);
        dw = (d.we == 1'b1) && (d.rd != 5'd0);
        f  = 3'b000;
        if (g.pc != d.pc) f = f | 3'b001;
        if (gw != dw || (gw && dw && g.rd != d.rd)) f = f | 3'b010;
        if (gw && dw && g.wdata != d.wdata) f = f | 3'b100;
        return f;
    endfunction

    function automatic bit model_ready(input bit dv);
        return !m_halt && (q.size() < DEPTH || (dv && q.size() > 0));
    endfunction

    function automatic void model_reset();
        q.delete();
        m_age = 0; m_over = 0; m_under = 0; m_tout = 0; m_halt = 0;
        m_match = 0; m_mm = 0; m_mf = 3'b000; m_ret = '0; m_err = '0;
    endfunction

    function automatic void model_step(input bit gv, input retire_rec_t g, input bit dv, input retire_rec_t d);
        bit rdy, popped, byp, have, err, stop, was_empty;
        retire_rec_t r;
        logic [2:0] f;
        rdy = model_ready(dv);
        m_match = 0; m_mm = 0; m_mf = 3'b000;
        if (m_halt) return;
        was_empty = (q.size() == 0);
        popped = 0; byp = 0; have = 0; err = 0; stop = 0; r = '0;
        if (dv) begin
            if (!was_empty) begin r = q.pop_front(); popped = 1; have = 1; end
            else if (gv) begin r = g; byp = 1; have = 1; end
            else begin m_under = 1; err = 1; end
        end
        if (have) begin
            f = exp_fields(r, d);
            if (f == 3'b000) begin
                m_match = 1;
                if (m_ret != 32'hffff_ffff) m_ret = m_ret + 1;
            end else begin
                m_mm = 1; m_mf = f; err = 1;
            end
        end
        if (err && m_err != 16'hffff) m_err = m_err + 1;
        if (gv && !byp) begin
            if (rdy) q.push_back(g);
            else m_over = 1;
        end
        if (q.size() == 0 || popped || was_empty) m_age = 0;
        else begin
            m_age++;
            if (m_age >= TMO) begin m_tout = 1; stop = 1; end
        end
`ifdef GOLDEN_SB_STOP_ON_ERROR_EN
        if (err || stop) m_halt = 1;
`else
        if (stop && err) m_halt = 0;
`endif
    endfunction

    task automatic cycle(input bit gv, input retire_rec_t g, input bit dv, input retire_rec_t d);
        gold_valid = gv; gold_pc = g.pc; gold_rd = g.rd; gold_we = g.we; gold_wdata = g.wdata;
        dut_valid = dv; dut_pc = d.pc; dut_rd = d.rd; dut_we = d.we; dut_wdata = d.wdata;
        #1;
        chk("gold_ready", gold_ready, model_ready(dv));
        model_step(gv, g, dv, d);
        @(posedge clk); #1;
        gold_valid = 0; dut_valid = 0;
        chk("match", match, m_match);
        chk("mismatch", mismatch, m_mm);
        chk("mismatch_field", mismatch_field, m_mf);
        chk("occupancy", occupancy, q.size());
        chk("retired_count", retired_count, m_ret);
        chk("error_count", error_count, m_err);
        chk("overflow", overflow, m_over);
        chk("underflow", underflow, m_under);
        chk("timeout", timeout, m_tout);
        chk("halted", halted, m_halt);
    endtask

    task automatic do_reset();
        reset = 1; gold_valid = 0; dut_valid = 0;
        @(posedge clk); #1;
        reset = 0;
        model_reset();
    endtask

    typedef struct {
        retire_rec_t g;
        retire_rec_t d;
        logic [2:0]  mf;
    } vec_t;

    vec_t        tbl[10];
    retire_rec_t z, g, b, d;
    bit          gv, dv;
    int          pg, pd;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        z = '0;
        tbl[0] = '{mk(32'h100, 5'd5, 1'b1, 32'h11), mk(32'h100, 5'd5, 1'b1, 32'h11), 3'b000};
        tbl[1] = '{mk(32'h100, 5'd5, 1'b1, 32'h11), mk(32'h104, 5'd5, 1'b1, 32'h11), 3'b001};
        tbl[2] = '{mk(32'h010, 5'd5, 1'b1, 32'h55), mk(32'h010, 5'd5, 1'b1, 32'h54), 3'b100};
        tbl[3] = '{mk(32'h020, 5'd0, 1'b1, 32'h77), mk(32'h020, 5'd0, 1'b0, 32'h00), 3'b000};
        tbl[4] = '{mk(32'h024, 5'd3, 1'b1, 32'h09), mk(32'h024, 5'd4, 1'b1, 32'h09), 3'b010};
        tbl[5] = '{mk(32'h028, 5'd3, 1'b1, 32'h09), mk(32'h028, 5'd3, 1'b0, 32'h09), 3'b010};
        tbl[6] = '{mk(32'h02c, 5'd3, 1'b0, 32'h01), mk(32'h02c, 5'd3, 1'b0, 32'h02), 3'b000};
        tbl[7] = '{mk(32'h030, 5'd0, 1'b1, 32'h01), mk(32'h030, 5'd0, 1'b1, 32'h02), 3'b000};
        tbl[8] = '{mk(32'h034, 5'd3, 1'b1, 32'h01), mk(32'h038, 5'd4, 1'b1, 32'h02), 3'b111};
        tbl[9] = '{mk(32'h03c, 5'd0, 1'b1, 32'h01), mk(32'h03c, 5'd4, 1'b1, 32'h01), 3'b010};

        // Reset state, sampled while reset is held.
        reset = 1; gold_valid = 0; dut_valid = 0;
        gold_pc = 0; gold_rd = 0; gold_we = 0; gold_wdata = 0;
        dut_pc = 0; dut_rd = 0; dut_we = 0; dut_wdata = 0;
        @(posedge clk); #1;
        chk("rst_ready", gold_ready, 0);
        chk("rst_match", {match, mismatch, mismatch_field}, 0);
        chk("rst_flags", {overflow, underflow, timeout, halted}, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_counts", {retired_count, error_count}, 0);
        chk("rst_state", dut.state, EMPTY);
        reset = 0;
        model_reset();

        // Field-compare table, applied as empty-FIFO bypass compares.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            cycle(1, tbl[i].g, 1, tbl[i].d);
            chk("tbl_field", mismatch_field, tbl[i].mf);
            chk("tbl_match", match, tbl[i].mf == 3'b000);
            chk("tbl_bypass_occ", occupancy, 0);
        end

        // Three buffered records retired later in order.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, mk(32'(i * 4), 5'd5, 1'b1, 32'(i + 1)), 0, z);
        cycle(0, z, 0, z);
        cycle(0, z, 0, z);
        for (int i = 0; i < 3; i++) begin
            cycle(0, z, 1, mk(32'(i * 4), 5'd5, 1'b1, 32'(i + 1)));
            chk("t1_match", match, 1);
        end
        chk("t1_retired", retired_count, 3);
        chk("t1_occ", occupancy, 0);
        chk("t1_state", dut.state, EMPTY);

        // Data mismatch through the FIFO path.
        do_reset();
        cycle(1, mk(32'h10, 5'd5, 1'b1, 32'h55), 0, z);
        cycle(0, z, 1, mk(32'h10, 5'd5, 1'b1, 32'h54));
        chk("t2_mismatch", mismatch, 1);
        chk("t2_field", mismatch_field, 3'b100);
        chk("t2_errors", error_count, 1);

        // Fill, overflow, then push and pop together while full; then reset mid-operation.
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1, mk(32'h200 + 32'(i * 4), 5'd1, 1'b1, 32'(i)), 0, z);
        cycle(1, mk(32'h300, 5'd1, 1'b1, 32'h9), 0, z);
        chk("t4_overflow", overflow, 1);
        chk("t4_occ_full", occupancy, DEPTH);
        cycle(1, mk(32'h304, 5'd1, 1'b1, 32'ha), 1, mk(32'h200, 5'd1, 1'b1, 32'h0));
        chk("t4_pushpop_match", match, 1);
        chk("t4_pushpop_occ", occupancy, DEPTH);
        do_reset();
        chk("t4_reset_occ", occupancy, 0);
        chk("t4_reset_overflow", overflow, 0);

        // Head waits TIMEOUT_CYCLES with no DUT retire.
        do_reset();
        cycle(1, mk(32'h40, 5'd2, 1'b1, 32'h7), 0, z);
        for (int i = 0; i < TMO - 1; i++) cycle(0, z, 0, z);
        chk("t5_no_timeout_yet", timeout, 0);
        cycle(0, z, 0, z);
        chk("t5_timeout", timeout, 1);
`ifndef GOLDEN_SB_STOP_ON_ERROR_EN
        chk("t5_stalled", dut.state, STALLED);
`endif
        cycle(0, z, 1, mk(32'h40, 5'd2, 1'b1, 32'h7));
`ifndef GOLDEN_SB_STOP_ON_ERROR_EN
        chk("t5_late_match", match, 1);
        chk("t5_empty", dut.state, EMPTY);
`endif

        // Underflow on empty FIFO.
        do_reset();
        cycle(0, z, 1, mk(32'h50, 5'd1, 1'b1, 32'h1));
        chk("t6_underflow", underflow, 1);
        chk("t6_errors", error_count, 1);
        chk("t6_no_pulse", {match, mismatch}, 0);
`ifdef GOLDEN_SB_STOP_ON_ERROR_EN
        chk("t6_halted", halted, 1);
        chk("t6_ready", gold_ready, 0);
`else
        chk("t6_halted", halted, 0);
        chk("t6_ready", gold_ready, 1);
`endif
        do_reset();
        chk("t6_reset_flags", {underflow, halted}, 0);
        chk("t6_reset_errors", error_count, 0);

        // Randomized traffic against the queue model, fill-biased then drain-biased.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            pg = (i < 400) ? 60 : 30;
            pd = (i < 400) ? 35 : 60;
            gv = ($urandom % 100) < pg;
            dv = ($urandom % 100) < pd;
            g  = mk(32'($urandom_range(0, 15) * 4), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 32'($urandom_range(0, 3)));
            if (q.size() > 0) b = q[0];
            else if (gv) b = g;
            else b = mk(32'h80, 5'd1, 1'b1, 32'h1);
            d = b;
            if (($urandom % 100) < 20) begin
                case ($urandom % 4)
                    0: d.pc = d.pc ^ 32'd4;
                    1: d.rd = d.rd ^ 5'd1;
                    2: d.we = ~d.we;
                    default: d.wdata = d.wdata ^ 32'd1;
                endcase
            end
            cycle(gv, g, dv, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/golden_retire_scoreboard.md
Name: golden_retire_scoreboard

Overview:
In-order retire-trace scoreboard between the golden_model_core (single-cycle, retires every instruction at once) and the next-generation pipelined core (retires later, with variable latency).
- Golden retire records are buffered in a parametrised FIFO.
- Each DUT retire is compared against the FIFO head: PC, rd, write-enable and write data.
- Reports per-instruction match/mismatch, overflow, underflow and retire timeout, plus saturating counters.
- Sits in the core testbench, fed by the golden interface's register-bank write port and the DUT retire port.

Parameters:
- DATA_BITS, 32, width of rd write data.
- PC_BITS, 32, width of retired PC.
- REG_ADDR_BITS, 5, register index width.
- DEPTH, 8, golden FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 64, maximum cycles the head entry may wait for a DUT retire.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- gold_valid  in  1  golden retire strobe.
- gold_pc  in  PC_BITS  golden retired PC.
- gold_rd  in  REG_ADDR_BITS  golden destination register.
- gold_we  in  1  golden register write enable.
- gold_wdata  in  DATA_BITS  golden write data.
- gold_ready  out  1  FIFO can accept a record (not full, or popping this cycle).
- dut_valid  in  1  DUT retire strobe.
- dut_pc  in  PC_BITS  DUT retired PC.
- dut_rd  in  REG_ADDR_BITS  DUT destination register.
- dut_we  in  1  DUT write enable.
- dut_wdata  in  DATA_BITS  DUT write data.
- match  out  1  one-cycle pulse, compare passed.
- mismatch  out  1  one-cycle pulse, compare failed.
- mismatch_field  out  3  {data, rd/we, pc} failing-field mask, valid with mismatch.
- overflow  out  1  sticky: golden push dropped while full.
- underflow  out  1  sticky: DUT retire with no golden record.
- timeout  out  1  sticky: head waited TIMEOUT_CYCLES.
- halted  out  1  stop-on-error state (optional feature only; otherwise tied 0).
- occupancy  out  $clog2(DEPTH)+1  FIFO fill level.
- retired_count  out  32  successful compares, saturating.
- error_count  out  16  mismatches plus underflows, saturating.

Behaviour:
Reset:
- All outputs 0, FIFO empty, timer 0, FSM in EMPTY.
- Reset mid-operation discards all entries and clears sticky flags in the same edge.

Push:
- gold_valid && gold_ready writes the record at the tail.
- gold_valid && !gold_ready drops the record and sets overflow.
- Full plus a simultaneous pop: the push is accepted and occupancy is unchanged.

Compare:
- dut_valid with occupancy>0 pops the head and compares.
- match/mismatch and mismatch_field are registered, asserted exactly 1 cycle after dut_valid.
- pc field: pc differs.
- rd field: effective write differs, where effective write = we && rd!=0; when both effective writes are set, rd must also be equal.
- data field: only checked when both effective writes are 1; wdata differs.
- x0 writes are treated as no write.
- Empty FIFO plus simultaneous gold_valid and dut_valid: bypass, i.e. compare against the incoming golden record and do not store it.
- Empty FIFO with dut_valid and no gold_valid: underflow set, error_count+1, no match/mismatch pulse.

FSM states:
- EMPTY: occupancy==0, timer held 0.
  - Push without pop goes to TRACKING.
- TRACKING: occupancy>0, timer increments each cycle, resets to 0 on every pop.
  - Last entry popped with no push goes to EMPTY.
  - Timer reaching TIMEOUT_CYCLES-1 sets timeout and goes to STALLED.
- STALLED: compares continue, timeout stays set.
  - Next pop goes back to TRACKING (or EMPTY if emptied).

Counters:
- retired_count+1 per match, error_count+1 per mismatch or underflow.
- Both saturate at all-ones and never wrap.

Pointers:
- Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Full/empty are derived from occupancy.

Optional Feature:
GOLDEN_SB_STOP_ON_ERROR_EN
- Defined:
  - First mismatch, underflow or timeout enters HALTED.
  - In HALTED: halted=1, gold_ready=0, further pushes are ignored without setting overflow, and compares are suppressed (no pulses, counters frozen).
  - Only reset leaves HALTED.
- Undefined: HALTED does not exist, halted is tied 0, and the block keeps comparing after errors.

Decomposition:
- Package golden_sb_pkg holds:
  - the retire_rec_t struct {pc, rd, we, wdata}, sized from package localparams matching the defaults;
  - sb_state_e {EMPTY, TRACKING, STALLED, HALTED};
  - the mismatch_field bit positions MF_PC=0, MF_RD=1, MF_DATA=2.
- One sub-module: golden_sb_fifo (synchronous FIFO of retire_rec_t; DEPTH parameter; push/pop/full/empty/occupancy; simultaneous push and pop legal when full).

Test Plan:
1. Push 3 records (pc 0x00, 0x04, 0x08; rd 5; wdata 1, 2, 3), then 3 identical DUT retires 2 cycles later -> 3 match pulses, retired_count=3, occupancy returns to 0, FSM EMPTY.
2. Golden pc 0x10, wdata 0x55; DUT pc 0x10, wdata 0x54 -> mismatch 1 cycle later, mismatch_field=3'b100, error_count=1.
3. Golden we=1 rd=0; DUT we=0 -> match (x0 write ignored).
4. Fill DEPTH=8 entries, push a 9th with no pop -> overflow=1, occupancy=8. Then push and pop in the same cycle -> accepted, occupancy stays 8.
5. One push, no DUT retire for 64 cycles -> timeout=1 at cycle 64, FSM STALLED. A matching retire then gives match and FSM EMPTY.
6. dut_valid on empty FIFO -> underflow=1, error_count=1. With GOLDEN_SB_STOP_ON_ERROR_EN: halted=1, gold_ready=0, and a later reset clears all.
